// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//
// Hardware call/data stack that owns a private stack RAM and the stack
// pointer. It executes PUSH/POP/CALL/RET requests from decode/execute and
// continuously drives sp_out into the register file's R31 (Write_From_Stack)
// input. POP and RET data return on dedicated outputs with one-cycle valid
// pulses.
//
// Parameters:
//   DEPTH     - number of 32-bit stack entries (power of two, >= 2)
//   ADDR_W    - log2(DEPTH)
//   STACK_TOP - byte address reported on sp_out when the stack is empty
//
// Ports:
//   clk        in   single clock, all state changes on its rising edge
//   reset      in   asynchronous active-high reset
//   op_valid   in   request present
//   op         in   3'b000 NOP, 001 PUSH, 010 POP, 011 CALL, 100 RET (else NOP)
//   push_data  in   word pushed by PUSH
//   ret_pc     in   return address pushed by CALL
//   op_ready   out  request can be accepted this cycle
//   pop_data   out  word returned by POP (valid with pop_valid)
//   pop_valid  out  one-cycle pulse
//   ret_addr   out  address returned by RET (valid with ret_valid)
//   ret_valid  out  one-cycle pulse
//   sp_out     out  STACK_TOP - 4*count
//   count      out  entries currently on the stack
//   full       out  count == DEPTH
//   empty      out  count == 0
//   overflow   out  sticky: PUSH/CALL attempted while full
//   underflow  out  sticky: POP/RET attempted while empty
// -----------------------------------------------------------------------------
module stack_unit #(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] STACK_TOP = 32'd1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [2:0]          op,
    input  logic signed [31:0]  push_data,
    input  logic [31:0]         ret_pc,
    output logic                op_ready,
    output logic signed [31:0]  pop_data,
    output logic                pop_valid,
    output logic [31:0]         ret_addr,
    output logic                ret_valid,
    output logic [31:0]         sp_out,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State registers and their next-state values
    // -------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [ADDR_W:0]    count_q,     count_d;
    logic               rd_ret_q,    rd_ret_d;     // pending read is a RET
    logic [31:0]        pop_data_q,  pop_data_d;
    logic [31:0]        ret_addr_q,  ret_addr_d;
    logic               pop_valid_q, pop_valid_d;
    logic               ret_valid_q, ret_valid_d;
    logic               overflow_q,  overflow_d;
    logic               underflow_q, underflow_d;

    // -------------------------------------------------------------------------
    // Stack RAM: one write port, one registered read port, no reset so it
    // maps onto block RAM.
    // -------------------------------------------------------------------------
    logic [31:0]        mem [DEPTH];
    logic               mem_we;
    logic               mem_re;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [ADDR_W-1:0]  mem_raddr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata_q;

    logic               full_w;
    logic               empty_w;

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    // Writes land at the current count; the top-of-stack read address is
    // count-1, sampled on the accepting edge so the data is ready for the
    // READ cycle. A write and a read are never requested on the same edge.
    assign mem_waddr = count_q[ADDR_W-1:0];
    assign mem_raddr = ADDR_W'(count_q - CNT_ONE);
    assign mem_wdata = (op == OP_CALL) ? ret_pc : push_data;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rdata_q <= mem[mem_raddr];
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rd_ret_q    <= 1'b0;
            pop_data_q  <= '0;
            ret_addr_q  <= '0;
            pop_valid_q <= 1'b0;
            ret_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ret_q    <= rd_ret_d;
            pop_data_q  <= pop_data_d;
            ret_addr_q  <= ret_addr_d;
            pop_valid_q <= pop_valid_d;
            ret_valid_q <= ret_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ret_d    = rd_ret_q;
        pop_data_d  = pop_data_q;
        ret_addr_d  = ret_addr_q;
        pop_valid_d = 1'b0;
        ret_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        op_ready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    case (op)
                        OP_PUSH, OP_CALL: begin
                            if (full_w) begin
                                overflow_d = 1'b1;
                            end else begin
                                mem_we  = 1'b1;
                                count_d = count_q + CNT_ONE;
                            end
                        end
                        OP_POP, OP_RET: begin
                            if (empty_w) begin
                                underflow_d = 1'b1;
                            end else begin
                                mem_re   = 1'b1;
                                count_d  = count_q - CNT_ONE;
                                rd_ret_d = (op == OP_RET);
                                state_d  = ST_READ;
                            end
                        end
                        default: ;  // NOP and illegal codes change nothing
                    endcase
                end
            end

            ST_READ: begin
                // RAM output is valid now; steer it to the matching port and
                // leave the other data output untouched.
                state_d = ST_IDLE;
                if (rd_ret_q) begin
                    ret_addr_d  = mem_rdata_q;
                    ret_valid_d = 1'b1;
                end else begin
                    pop_data_d  = mem_rdata_q;
                    pop_valid_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs. sp_out/full/empty depend on count only (modulo-2^32 arithmetic).
    // -------------------------------------------------------------------------
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign ret_addr  = ret_addr_q;
    assign ret_valid = ret_valid_q;
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign sp_out    = STACK_TOP - (32'(count_q) << 2);

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

    logic               clk;
    logic               reset;
    logic               op_valid;
    logic [2:0]         op;
    logic signed [31:0] push_data;
    logic [31:0]        ret_pc;
    logic               op_ready;
    logic signed [31:0] pop_data;
    logic               pop_valid;
    logic [31:0]        ret_addr;
    logic               ret_valid;
    logic [31:0]        sp_out;
    logic [6:0]         count;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               underflow;

    int n_total  = 0;
    int n_passed = 0;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] PUSH = 3'b001;
    localparam logic [2:0] POP  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;

    stack_unit #(
        .DEPTH     (64),
        .ADDR_W    (6),
        .STACK_TOP (32'd1024)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .push_data (push_data),
        .ret_pc    (ret_pc),
        .op_ready  (op_ready),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .ret_addr  (ret_addr),
        .ret_valid (ret_valid),
        .sp_out    (sp_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one edge (op_ready is known high).
    task automatic issue(input logic [2:0] code, input logic [31:0] data);
        op_valid  = 1'b1;
        op        = code;
        push_data = data;
        ret_pc    = data;
        tick();
        op_valid  = 1'b0;
        op        = NOP;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_sp"},        sp_out,    32'd1024);
        check({pfx, "_count"},     32'(count), 32'd0);
        check({pfx, "_empty"},     32'(empty), 32'd1);
        check({pfx, "_full"},      32'(full),  32'd0);
        check({pfx, "_ready"},     32'(op_ready), 32'd1);
        check({pfx, "_ovf"},       32'(overflow), 32'd0);
        check({pfx, "_unf"},       32'(underflow), 32'd0);
        check({pfx, "_pvalid"},    32'(pop_valid), 32'd0);
        check({pfx, "_rvalid"},    32'(ret_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        op_valid  = 1'b0;
        op        = NOP;
        push_data = '0;
        ret_pc    = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ---- Reset state ----
        check_reset_state("rst");
        check("rst_pop_data", pop_data, 32'd0);
        check("rst_ret_addr", ret_addr, 32'd0);

        // ---- PUSH 7, PUSH -3, POP, POP ----
        issue(PUSH, 32'd7);
        check("push1_count", 32'(count), 32'd1);
        check("push1_sp", sp_out, 32'd1020);
        issue(PUSH, -32'sd3);
        check("push2_sp", sp_out, 32'd1016);
        check("push2_empty", 32'(empty), 32'd0);

        issue(POP, 32'd0);
        check("pop1_ready_low", 32'(op_ready), 32'd0);
        check("pop1_count", 32'(count), 32'd1);
        check("pop1_sp", sp_out, 32'd1020);
        check("pop1_no_early_valid", 32'(pop_valid), 32'd0);
        tick();
        check("pop1_valid", 32'(pop_valid), 32'd1);
        check("pop1_data", pop_data, 32'hFFFF_FFFD);
        check("pop1_ready_back", 32'(op_ready), 32'd1);
        check("pop1_no_ret_valid", 32'(ret_valid), 32'd0);
        tick();
        check("pop1_valid_pulse_end", 32'(pop_valid), 32'd0);

        issue(POP, 32'd0);
        tick();
        check("pop2_valid", 32'(pop_valid), 32'd1);
        check("pop2_data", pop_data, 32'd7);
        check("pop2_sp", sp_out, 32'd1024);
        check("pop2_empty", 32'(empty), 32'd1);
        tick();

        // ---- CALL 0x40, RET ----
        issue(CALL, 32'h40);
        check("call_sp", sp_out, 32'd1020);
        issue(RET, 32'd0);
        check("ret_ready_low", 32'(op_ready), 32'd0);
        tick();
        check("ret_valid", 32'(ret_valid), 32'd1);
        check("ret_addr", ret_addr, 32'h40);
        check("ret_no_pop_valid", 32'(pop_valid), 32'd0);
        check("ret_pop_data_held", pop_data, 32'd7);
        tick();
        check("ret_valid_pulse_end", 32'(ret_valid), 32'd0);
        check("ret_sp", sp_out, 32'd1024);

        // ---- PUSH accepted while pop_valid is high ----
        issue(PUSH, 32'd11);
        issue(POP, 32'd0);
        op_valid  = 1'b1;
        op        = PUSH;
        push_data = 32'd22;
        tick();
        check("pushpulse_valid", 32'(pop_valid), 32'd1);
        check("pushpulse_data", pop_data, 32'd11);
        check("pushpulse_ready", 32'(op_ready), 32'd1);
        tick();
        op_valid = 1'b0;
        op       = NOP;
        check("pushpulse_count", 32'(count), 32'd1);
        issue(POP, 32'd0);
        tick();
        check("pushpulse_pop_data", pop_data, 32'd22);
        tick();

        // ---- Fill to 64, then overflow ----
        for (int i = 0; i < 64; i++) begin
            issue(PUSH, 32'(i * 3 + 100));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_sp", sp_out, 32'd768);
        check("fill_count", 32'(count), 32'd64);
        check("fill_ovf_clear", 32'(overflow), 32'd0);
        issue(PUSH, 32'hDEAD_BEEF);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd64);
        check("ovf_ready", 32'(op_ready), 32'd1);
        issue(POP, 32'd0);
        tick();
        check("ovf_pop_data", pop_data, 32'd289);
        check("ovf_pop_count", 32'(count), 32'd63);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // ---- Reset, underflow, reset during READ ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        check_reset_state("rst2");

        issue(POP, 32'd0);
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        check("unf_ready", 32'(op_ready), 32'd1);
        tick();
        check("unf_no_pvalid", 32'(pop_valid), 32'd0);

        issue(PUSH, 32'd55);
        op_valid = 1'b1;
        op       = POP;
        tick();
        check("midread_ready_low", 32'(op_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("midread_rst_ready", 32'(op_ready), 32'd1);
        op_valid = 1'b0;
        op       = NOP;
        @(posedge clk);
        #1;
        check("midread_rst_no_pulse", 32'(pop_valid), 32'd0);
        reset = 1'b0;
        tick();
        check_reset_state("rst3");
        check("rst3_pop_data", pop_data, 32'd0);
        tick();
        check("rst3_still_no_pulse", 32'(pop_valid), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware call/data stack feeding the register file's stack-pointer register R31: it owns a private stack RAM and the stack pointer, executes PUSH/POP/CALL/RET requests from the decode/execute stage, and drives `sp_out` continuously into the register file's `Write_From_Stack` input. POP and RET data return on dedicated outputs for the writeback and branch logic.

## Interface
- `DEPTH`, 64, stack entries, 32-bit each; power of two, ≥ 2
- `ADDR_W`, 6, log2(DEPTH)
- `STACK_TOP`, 32'd1024, byte address reported in `sp_out` when the stack is empty

- `clk` in 1: single clock; all state changes on its rising edge
- `reset` in 1: asynchronous, active-high; clears all state below
- `op_valid` in 1: request present
- `op` in 3: 3'b000 NOP, 3'b001 PUSH, 3'b010 POP, 3'b011 CALL, 3'b100 RET; other codes are treated as NOP
- `push_data` in 32 signed: word pushed by PUSH
- `ret_pc` in 32: return address pushed by CALL
- `op_ready` out 1: block can accept a request this cycle
- `pop_data` out 32 signed: word returned by POP
- `pop_valid` out 1: one-cycle pulse; `pop_data` is valid
- `ret_addr` out 32: address returned by RET
- `ret_valid` out 1: one-cycle pulse; `ret_addr` is valid
- `sp_out` out 32: STACK_TOP − 4·count; drives the register file's R31 input
- `count` out ADDR_W+1: entries currently on the stack
- `full`, `empty` out 1: count==DEPTH, count==0
- `overflow`, `underflow` out 1: sticky error flags, cleared only by reset

## Operation
- A request is accepted on a rising edge where `op_valid && op_ready`. NOP and illegal codes are accepted and change nothing.
- FSM states:
  - IDLE, `op_ready`=1.
  - READ, `op_ready`=0.
- IDLE transitions:
  - PUSH or CALL, not full: `mem[count]` ← `push_data` / `ret_pc`; count+1. Stay in IDLE.
  - PUSH or CALL, full: no write; count unchanged; `overflow` ← 1. Stay in IDLE.
  - POP or RET, not empty: count−1; latch read address count−1 and the op kind; go to READ.
  - POP or RET, empty: no state change; `underflow` ← 1; no valid pulse. Stay in IDLE.
- READ to IDLE, unconditionally on the next edge:
  - POP: `pop_data` ← mem[addr]; `pop_valid` pulses.
  - RET: `ret_addr` ← mem[addr]; `ret_valid` pulses.
  - The other data output holds its previous value.
- RAM read is synchronous and fits block RAM. RAM contents are not reset.
- `sp_out`, `full` and `empty` are registered or derived from `count` only, with no combinational path from `op`.
- `sp_out` arithmetic is 32-bit modulo: STACK_TOP − (count<<2).

## Timing
- Reset values:
  - `op_ready`=1.
  - `pop_data`, `ret_addr` = 0; `pop_valid`, `ret_valid` = 0.
  - `count`=0; `sp_out`=STACK_TOP.
  - `full`=0, `empty`=1; `overflow`, `underflow` = 0.
  - FSM in IDLE.
- PUSH/CALL: single cycle. `count` and `sp_out` show the new value in the cycle after the accepting edge N.
- POP/RET, accepted at edge N:
  - `count` and `sp_out` update after edge N.
  - `op_ready`=0 between edges N and N+1.
  - `pop_valid`/`ret_valid`=1 between edges N+1 and N+2.
  - Sustained throughput is one pop per 2 cycles.
- A request arriving during READ is not accepted. The source holds `op` and `op_valid` until it sees `op_ready`=1.
- A PUSH issued in the cycle a `pop_valid` pulse is high is legal and accepted.
- PUSH then POP back-to-back returns the just-pushed word; write and read never collide, because READ follows acceptance.
- Reset asserted during READ: FSM returns to IDLE and no valid pulse is emitted.
- Error flags set on the accepting edge and stay set; the offending op still consumes its cycle.

## Test plan
- Reset: after `reset` pulse → `sp_out`=1024, `count`=0, `empty`=1, `op_ready`=1, all flags 0.
- PUSH 32'd7, PUSH −32'd3, POP, POP:
  - After the pushes, `sp_out`=1016.
  - First pop: `pop_data`=−3, with `pop_valid` one cycle and `op_ready` low one cycle.
  - Second pop: `pop_data`=7.
  - Final `sp_out`=1024.
- CALL `ret_pc`=32'h40, then RET → `ret_addr`=32'h40, `ret_valid` pulses once, `pop_valid` stays 0, `pop_data` unchanged.
- 64 PUSHes then one more PUSH:
  - After the 64 pushes, `full`=1 and `sp_out`=768.
  - The 65th sets `overflow`=1; `count` stays 64.
  - The next POP returns the 64th value.
- POP on empty → `underflow`=1, no `pop_valid`, `count` stays 0. Hold POP through READ, then assert `reset` mid-READ → no pulse, full reset state.
